mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-client arbiter and transaction sequencer in front of the 128-bit line memory (SRAM-backed, requested/ready handshake, 5-cycle busy window).
- Accepts line-fill requests from the instruction cache, and read/write requests from the data cache.
- Grants one at a time with alternating priority, and drives the memory handshake.
- Returns the read line to the owner with a one-cycle valid pulse.

Parameters:
- ADDR_W, 20, word address width, matching the memory address port.
- LINE_W, 128, line width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  instruction-cache line-read request (level)
- ic_addr  in  ADDR_W  instruction-cache line address
- ic_abort  in  1  pipeline flush: kill any pending or in-flight IC transaction
- ic_valid  out  1  one-cycle pulse: ic_rd_data valid
- ic_rd_data  out  LINE_W  returned instruction line
- dc_req  in  1  data-cache request (level)
- dc_we  in  1  1 = write line, 0 = read line
- dc_addr  in  ADDR_W  data-cache line address
- dc_wr_data  in  LINE_W  write line
- dc_valid  out  1  one-cycle pulse: read data valid or write complete
- dc_rd_data  out  LINE_W  returned data line
- loading  in  1  memory preload in progress; blocks new grants
- mem_requested  out  1  request to memory
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wr_data  out  LINE_W  write data to memory
- mem_reset_req  out  1  one-cycle cancel pulse to memory
- mem_ready  in  1  memory idle (busy counter == 0)
- mem_rd_data  in  LINE_W  memory read line
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values:
  - State IDLE; last_grant = IC, so DC wins the first tie.
  - mem_requested, mem_we, mem_reset_req, ic_valid, dc_valid all 0.
  - ic_rd_data, dc_rd_data, mem_addr, mem_wr_data all 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If !loading and a request is eligible, latch owner, we, addr and wr_data into the mem_* registers and go to ISSUE.
  - A client's req is ignored in the cycle its own valid is high, so a level-held req is not double-granted.
  - Tie between IC and DC: grant the client that is not last_grant. Update last_grant on every grant.
  - A dc_we=1 grant latches dc_wr_data; a read grant forces mem_we = 0.
- ISSUE: mem_requested = 1 (memory is ready at this point). Next state WAIT.
- WAIT:
  - mem_requested = !mem_ready; it stays high through the busy window because the memory muxes write words only while requested is high.
  - When mem_ready = 1, go to DONE. mem_requested is already 0 that cycle, so the memory does not restart.
- DONE:
  - Load mem_rd_data into the owner's rd_data register (write transactions leave it unchanged).
  - Set the owner's valid for the next cycle; go to IDLE.
- Latency: req sampled in IDLE at cycle T → ISSUE T+1 → mem_ready low T+2..T+6 → WAIT exits at T+7 → DONE T+8 → valid pulse at T+9.
- Back-to-back: the FSM is in IDLE at T+9, so a new grant goes out at T+9 and the next ISSUE is at T+10.
- Abort:
  - ic_abort while owner = IC and state is ISSUE or WAIT: pulse mem_reset_req for one cycle, go to IDLE, no ic_valid.
  - ic_abort in DONE with owner = IC: suppress ic_valid; still return to IDLE.
  - ic_abort in IDLE: that cycle's ic_req is ineligible.
  - DC transactions are never aborted.
- loading:
  - Only blocks new grants.
  - If asserted mid-transaction, the transaction completes normally.
  - mem_requested stays 0 while IDLE and loading.
- Reset mid-transaction: FSM returns to IDLE, no valid pulse. mem_reset_req is not pulsed, because memory reset clears memory state as well.
- Widths: addresses pass through unmodified; no arithmetic on addresses or data.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W, LINE_W.
  - State enum (IDLE/ISSUE/WAIT/DONE).
  - Owner enum (OWN_IC/OWN_DC).
  - MEM_BUSY_CYCLES = 5.
- Sub-module rr_arb2: combinational 2-way alternating-priority select from req vectors and last_grant. The FSM and datapath stay in mem_arbiter.

Test Plan:
- IC read only: ic_req=1, ic_addr=0x00010; memory model returns 0xDEADBEEF_0 pattern → ic_valid at T+9 with that line. dc_valid stays 0; ic_req held → second grant at T+10.
- DC write: dc_we=1, dc_addr=0x00020, dc_wr_data=0x44..33..22..11 → mem_we=1 and mem_requested=1 from T+1 through T+6, 0 at T+7. dc_valid at T+9; the model stores four words at 0x20..0x23.
- Simultaneous requests after reset → DC granted first. IC is granted in the IDLE cycle at the DC valid, and IC valid arrives 9 cycles later.
- Abort: IC read, ic_abort pulsed at T+4 → mem_reset_req=1 at T+4 only, FSM in IDLE at T+5, ic_valid never asserted. A pending dc_req is granted at T+5.
- loading=1 with ic_req=1 for 10 cycles → mem_requested stays 0. Deassert loading → grant the next cycle.
- Reset at T+5 of a DC write → all outputs return to reset values next cycle; no dc_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizes for the two-client line-memory arbiter.
package mem_pkg;

   localparam int ADDR_W          = 20;
   localparam int LINE_W          = 128;
   localparam int MEM_BUSY_CYCLES = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IC = 1'b0,
      OWN_DC = 1'b1
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way alternating-priority select: on a tie the client that did not win last time goes.
module rr_arb2
   import mem_pkg::*;
(
   input  logic [1:0] req,          // [0] = IC, [1] = DC
   input  owner_t     last_grant,
   output logic       grant_valid,
   output owner_t     grant_owner
);

   always_comb begin
      grant_valid = req[0] | req[1];
      grant_owner = OWN_IC;
      if (req[0] && req[1])
         grant_owner = (last_grant == OWN_IC) ? OWN_DC : OWN_IC;
      else if (req[1])
         grant_owner = OWN_DC;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IC line fills and DC reads/writes onto the line memory, one transaction at a time,
// and returns each result to its owner with a one-cycle valid pulse.
module mem_arbiter
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              ic_abort,
   output logic              ic_valid,
   output logic [LINE_W-1:0] ic_rd_data,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wr_data,
   output logic              dc_valid,
   output logic [LINE_W-1:0] dc_rd_data,
   input  logic              loading,
   output logic              mem_requested,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wr_data,
   output logic              mem_reset_req,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rd_data,
   output logic              busy
);

   state_t state_reg;
   owner_t owner_reg;
   owner_t last_grant_reg;
   logic   we_reg;
   logic   grant_valid;
   owner_t grant_owner;
   logic   abort_now;

   // A client is not eligible in the cycle its own valid is high, so a held req is not re-granted.
   rr_arb2 u_arb (
      .req         ({dc_req & ~dc_valid, ic_req & ~ic_valid & ~ic_abort}),
      .last_grant  (last_grant_reg),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   assign abort_now = ic_abort && (owner_reg == OWN_IC) &&
                      ((state_reg == ISSUE) || (state_reg == WAIT));

   // Requested stays high through the busy window and drops the cycle memory reports ready.
   assign mem_requested = !abort_now &&
                          ((state_reg == ISSUE) || ((state_reg == WAIT) && !mem_ready));
   assign mem_we        = we_reg && mem_requested;
   assign mem_reset_req = abort_now;
   assign busy          = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= OWN_IC;
         last_grant_reg <= OWN_IC;
         we_reg         <= 1'b0;
         mem_addr       <= '0;
         mem_wr_data    <= '0;
         ic_valid       <= 1'b0;
         dc_valid       <= 1'b0;
         ic_rd_data     <= '0;
         dc_rd_data     <= '0;
      end else begin
         ic_valid <= 1'b0;
         dc_valid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!loading && grant_valid) begin
                  owner_reg      <= grant_owner;
                  last_grant_reg <= grant_owner;
                  state_reg      <= ISSUE;
                  if (grant_owner == OWN_DC) begin
                     mem_addr <= dc_addr;
                     we_reg   <= dc_we;
                     if (dc_we)
                        mem_wr_data <= dc_wr_data;
                  end else begin
                     mem_addr <= ic_addr;
                     we_reg   <= 1'b0;
                  end
               end
            end
            ISSUE: state_reg <= abort_now ? IDLE : WAIT;
            WAIT: begin
               if (abort_now)
                  state_reg <= IDLE;
               else if (mem_ready)
                  state_reg <= DONE;
            end
            DONE: begin
               state_reg <= IDLE;
               if (owner_reg == OWN_DC) begin
                  dc_valid <= 1'b1;
                  if (!we_reg)
                     dc_rd_data <= mem_rd_data;
               end else if (!ic_abort) begin
                  ic_valid   <= 1'b1;
                  ic_rd_data <= mem_rd_data;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
